// File: rtl/mapper_pkg.sv
// Shared definitions for the TX request mapper and its read return path.
// Holds the mapped address layout, request type, field widths and the
// per-entry state used by the reorder buffer.
package mapper_pkg;

    localparam int BG_W    = 2;
    localparam int BANK_W  = 2;
    localparam int ROW_W   = 16;
    localparam int COL_W   = 10;
    localparam int MADDR_W = BG_W + BANK_W + ROW_W + COL_W;

    // Mapped address as issued by the mapper: {bg, bank, row, column}.
    typedef struct packed {
        logic [BG_W-1:0]   bank_group;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  column;
    } address_type;

    typedef enum logic [1:0] {
        REQ_READ  = 2'd0,
        REQ_WRITE = 2'd1
    } req_type;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } entry_state_e;

endpackage

// File: rtl/addr_demap.sv
// Purpose: inverse of the mapper address scheme, mapped {bg,bank,row,col} -> flat address.
// Latency: purely combinational.
// Backpressure: none, no handshake.
// Ports: maddr_i (mapped address struct), addr_o (flat address).
module addr_demap
    import mapper_pkg::*;
(
    input  address_type        maddr_i,
    output logic [MADDR_W-1:0] addr_o
);

    // Flat layout: [29:14] row, [13:12] bank, [11:6] col[9:4], [5:4] bg, [3:0] col[3:0].
    always_comb begin
        addr_o = {maddr_i.row,
                  maddr_i.bank,
                  maddr_i.column[COL_W-1:4],
                  maddr_i.bank_group,
                  maddr_i.column[3:0]};
    end

endmodule

// File: rtl/read_return_demapper.sv
// Purpose: in-order read ID allocation, out-of-order completion capture, in-order release with address demap.
// Latency: a completion to the head entry shows on rsp_valid one cycle later; no same-cycle bypass.
// Backpressure: rsp_* held stable while rsp_ready=0; alloc_ready drops when all DEPTH entries are in use.
// Ports: alloc_valid/alloc_ready/alloc_maddr/alloc_id (ID grant), ret_valid/ret_id/ret_data (bank
//        completions), rsp_valid/rsp_ready/rsp_address/rsp_data (ordered responses), err_spurious (sticky).
module read_return_demapper
    import mapper_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30,
    parameter int DEPTH  = 64,
    parameter int ID_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [ADDR_W-1:0] alloc_maddr,
    output logic [ID_W-1:0]   alloc_id,
    input  logic              ret_valid,
    input  logic [ID_W-1:0]   ret_id,
    input  logic [DATA_W-1:0] ret_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_address,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err_spurious
);

    localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(DEPTH);

    entry_state_e      state_q [DEPTH];
    entry_state_e      state_d [DEPTH];
    address_type       maddr_q [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];

    logic [ID_W-1:0] head_q, head_d;
    logic [ID_W-1:0] tail_q, tail_d;
    logic [ID_W:0]   count_q, count_d;
    logic            err_q, err_d;

    logic alloc_fire;
    logic rel_fire;
    logic ret_hit;

    assign alloc_ready = (count_q != FULL_CNT);
    assign alloc_id    = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign rsp_valid   = (state_q[head_q] == DONE);
    assign rel_fire    = rsp_valid && rsp_ready;
    assign rsp_data    = data_q[head_q];

    // A completion only lands on an entry still waiting for data; this also
    // makes a return to the ID being allocated this cycle spurious (still FREE).
    assign ret_hit     = ret_valid && (state_q[ret_id] == PENDING);

    assign err_spurious = err_q;

    addr_demap u_addr_demap (
        .maddr_i (maddr_q[head_q]),
        .addr_o  (rsp_address)
    );

    // Alloc writes the tail (FREE), return writes a PENDING entry and release
    // clears the head (DONE), so the three updates never target the same entry.
    always_comb begin
        state_d = state_q;
        if (alloc_fire) begin
            state_d[tail_q] = PENDING;
        end
        if (ret_hit) begin
            state_d[ret_id] = DONE;
        end
        if (rel_fire) begin
            state_d[head_q] = FREE;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q || (ret_valid && !ret_hit);
        if (alloc_fire) begin
            tail_d = tail_q + ID_W'(1);
        end
        if (rel_fire) begin
            head_d = head_q + ID_W'(1);
        end
        case ({alloc_fire, rel_fire})
            2'b10:   count_d = count_q + (ID_W+1)'(1);
            2'b01:   count_d = count_q - (ID_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= FREE;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Payload storage needs no reset: it is only observed once its entry is DONE.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            maddr_q[tail_q] <= address_type'(alloc_maddr);
        end
        if (ret_hit) begin
            data_q[ret_id] <= ret_data;
        end
    end

endmodule
